spm_seq: RTL and testbench

Sequencer for the serial-parallel multiplier (`spm`) datapath. It accepts a signed operand pair over a valid/ready handshake and drives the multiplier core. While the core runs, it holds the parallel operand `x`, shifts the serial operand `y` in LSB-first with sign extension, and deserialises the serial product into a 2·N-bit result. It sits between the requesting logic and a single `spm` instance, and it also drains the core's carry-save state between operations.

---
 rtl/spm_pkg.sv | 18 +
 rtl/spm_seq_deser.sv | 28 ++
 rtl/spm_seq.sv | 139 +++++++++++++
 tb/tb_spm_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier sequencer.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } spm_seq_state_t;

  localparam int SPM_N = 32;

  // Bit counter must reach 2N+LAT-1 during RUN.
  function automatic int spm_cnt_w(input int n, input int lat);
    return $clog2(2 * n + lat + 1);
  endfunction

endpackage

// File: rtl/spm_seq_deser.sv
// Serial product capture: each enabled bit enters at the MSB and the register shifts
// right, so after 2N captures the first bit received sits at bit 0.
module spm_seq_deser #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic           bit_i,
  output logic [2*N-1:0] p_o
);

  logic [2*N-1:0] p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
    end else if (clr_i) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= {bit_i, p_q[2*N-1:1]};
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/spm_seq.sv
// Sequencer driving a serial-parallel multiplier core: RUN streams y, FLUSH drains the core.
// Optional macro SPM_SEQ_PERF_EN adds perf_ops / perf_stall counters.
module spm_seq
  import spm_pkg::*;
#(
  parameter int N         = SPM_N,
  parameter int LAT       = 1,
  parameter int FLUSH_CYC = N + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic [N-1:0]   spm_x,
  output logic           spm_y,
  input  logic           spm_p
`ifdef SPM_SEQ_PERF_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_stall
`endif
);

  localparam int RUN_W   = spm_cnt_w(N, LAT);
  localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
  localparam int CNT_W   = (RUN_W > FLUSH_W) ? RUN_W : FLUSH_W;

  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(2 * N + LAT - 1);
  // The IDLE cycle after FLUSH also presents zero operands, completing the drain.
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 2);
  localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(LAT);

  spm_seq_state_t   state_q;
  logic [CNT_W-1:0] k_q;
  logic [N-1:0]     x_q;
  logic [N-1:0]     y_shift_q;
  logic             out_valid_q;
  logic             taken_q;
  logic             accept;
  logic             out_hs;
  logic             capture_en;

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid_q && out_ready;
  assign capture_en = (state_q == RUN) && (k_q >= LAT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_shift_q   <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q       <= in_x;
            y_shift_q <= in_y;
            k_q       <= '0;
            taken_q   <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          y_shift_q <= N'($signed(y_shift_q) >>> 1);
          if (k_q == RUN_LAST) begin
            k_q         <= '0;
            x_q         <= '0;
            y_shift_q   <= '0;
            out_valid_q <= 1'b1;
            state_q     <= FLUSH;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        FLUSH: begin
          if (out_hs) begin
            taken_q     <= 1'b1;
            out_valid_q <= 1'b0;
          end
          if (k_q == FLUSH_LAST) begin
            k_q     <= '0;
            state_q <= (taken_q || out_hs) ? IDLE : DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spm_seq_deser #(.N(N)) u_deser (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (capture_en),
    .bit_i (spm_p),
    .p_o   (out_p)
  );

  assign spm_x     = x_q;
  assign spm_y     = y_shift_q[0];
  assign out_valid = out_valid_q;

`ifdef SPM_SEQ_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Stall counts DONE cycles spent waiting on the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_hs) perf_ops_q <= perf_ops_q + 32'd1;
      if ((state_q == DONE) && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq with a behavioural serial-parallel multiplier core (LAT=1).
module tb_spm_seq;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_x = '0;
  logic [N-1:0]   in_y = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] out_p;
  logic [N-1:0]   spm_x;
  logic           spm_y;
  logic           spm_p;
`ifdef SPM_SEQ_PERF_EN
  logic [31:0]    perf_ops;
  logic [31:0]    perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  spm_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p)
`ifdef SPM_SEQ_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: each y bit adds sign-extended x to the running sum, the LSB leaves
  // one cycle later. Zero-operand cycles decay the residual towards zero (drain).
  logic signed [127:0] acc_q;
  logic signed [127:0] xs_w;
  logic signed [127:0] sum_w;
  logic                p_q;

  assign xs_w  = {{(128-N){spm_x[N-1]}}, spm_x};
  assign sum_w = spm_y ? (acc_q + xs_w) : acc_q;
  assign spm_p = p_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      p_q   <= 1'b0;
    end else if ((spm_x == '0) && !spm_y) begin
      acc_q <= acc_q / 128'sd2;
      p_q   <= acc_q[0];
    end else begin
      acc_q <= sum_w >>> 1;
      p_q   <= sum_w[0];
    end
  end

  typedef struct {
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept_op(input logic [N-1:0] x, input logic [N-1:0] y, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    check("in_ready_wait", {63'b0, ok}, 64'd1);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    acc_cyc  = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = $urandom;
    in_y     = $urandom;
    check("spm_x_loaded", 64'(spm_x), 64'(x));
    check("spm_y_first", {63'b0, spm_y}, {63'b0, y[0]});
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_acc, t_prev, lat;

    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1};
    vecs[2] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[4] = '{32'd7,         32'hFFFFFFF7, 64'hFFFFFFFFFFFFFFC1};
    vecs[5] = '{32'd0,         32'h12345678, 64'd0};
    vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
    vecs[7] = '{32'hFFFF0000, 32'h00010001, 64'hFFFFFFFEFFFF0000};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_p", out_p, 64'd0);
    check("rst_spm_x", 64'(spm_x), 64'd0);
    check("rst_spm_y", {63'b0, spm_y}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back products with the consumer always ready
    out_ready = 1'b1;
    t_prev    = 0;
    for (int i = 0; i < 8; i++) begin
      accept_op(vecs[i].x, vecs[i].y, t_acc);
      if (i > 0) check("accept_gap", 64'(t_acc - t_prev), 64'd98);
      t_prev = t_acc;
      wait_valid(lat);
      check("latency", 64'(lat), 64'd66);
      check("product", out_p, vecs[i].p);
      $display("op %0d: x=%h y=%h p=%h lat=%0d", i, vecs[i].x, vecs[i].y, out_p, lat);
      @(negedge clk);
      check("valid_drop", {63'b0, out_valid}, 64'd0);
      check("busy_in_flush", {63'b0, in_ready}, 64'd0);
    end

    // Reset in the middle of RUN (k=20)
    accept_op(32'd11, 32'd13, t_acc);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_out_p", out_p, 64'd0);
    check("midrst_spm_x", 64'(spm_x), 64'd0);
    check("midrst_spm_y", {63'b0, spm_y}, 64'd0);
    $display("op reset: asserted at RUN k=20");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Stalled consumer: out_ready low for 200 cycles from the first out_valid
    out_ready = 1'b0;
    accept_op(32'd6, 32'd7, t_acc);
    wait_valid(lat);
    check("stall_latency", 64'(lat), 64'd66);
    check("stall_product", out_p, 64'd42);
    repeat (40) @(negedge clk);
    check("done_out_valid", {63'b0, out_valid}, 64'd1);
    check("done_in_ready", {63'b0, in_ready}, 64'd0);
    check("done_out_p_held", out_p, 64'd42);
    repeat (160) @(negedge clk);
    check("done_still_valid", {63'b0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {63'b0, in_ready}, 64'd1);
    check("release_out_valid", {63'b0, out_valid}, 64'd0);
`ifdef SPM_SEQ_PERF_EN
    check("perf_stall", 64'(perf_stall), 64'd168);
    check("perf_ops", 64'(perf_ops), 64'd1);
`endif
    $display("op stall: x=6 y=7 p=%h lat=%0d", out_p, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
